// File: rtl/creg_pkg.sv
// Shared types and constants for the common register file (CREG) write-port arbitration.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package creg_pkg;

    // Register index of the common register file shared between processors.
    localparam logic [4:0] CREG_IDX = 5'd26;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/creg_arbiter_if.sv
// Bundle of requester-side and register-file-side signals of the CREG arbiter.
// Latency: none (wiring only).
// Backpressure: grant/stall flow from slave (arbiter) to master (processor cluster).
// Ports: wr_req/rd_req/lock/wr_dst/wr_data in from processors; grant/stall back to them;
//        rf_we/rf_dst/rf_data to the shared register file; locked/owner/lock_err/conflict_cnt status.
interface creg_arbiter_if #(
    parameter int NREQ = 2
);
    import creg_pkg::*;

    localparam int PTR_W = idx_w(NREQ);

    logic [NREQ-1:0]        wr_req;
    logic [NREQ-1:0]        rd_req;
    logic [NREQ-1:0]        lock;
    logic [NREQ*REG_W-1:0]  wr_dst;
    logic [NREQ*DATA_W-1:0] wr_data;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        stall;
    logic                   rf_we;
    logic [REG_W-1:0]       rf_dst;
    logic [DATA_W-1:0]      rf_data;
    logic                   locked;
    logic [PTR_W-1:0]       owner;
    logic                   lock_err;
    logic [15:0]            conflict_cnt;

    modport master (
        output wr_req, rd_req, lock, wr_dst, wr_data,
        input  grant, stall, rf_we, rf_dst, rf_data, locked, owner, lock_err, conflict_cnt
    );

    modport slave (
        input  wr_req, rd_req, lock, wr_dst, wr_data,
        output grant, stall, rf_we, rf_dst, rf_data, locked, owner, lock_err, conflict_cnt
    );

endinterface

// File: rtl/creg_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the first asserted req at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; losers are simply not granted.
// Ports: req (request vector), ptr (highest-priority index), grant (one-hot or zero).
module rr_pick
    import creg_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]        req,
    input  logic [idx_w(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]        grant
);

    logic found;

    // Two passes: first the indices at or above ptr, then the wrapped lower ones.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/creg_arbiter.sv
// Round-robin arbiter and exclusive-lock controller for the shared CREG write port.
// Latency: grant/stall/rf_* combinational (zero cycles); locked/owner/lock_err/conflict_cnt registered.
// Backpressure: losing or locked-out requesters see stall and hold their request until granted.
// Ports: CLK, RST (async active-high); bus (slave modport of creg_arbiter_if).
module creg_arbiter
    import creg_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int LOCK_MAX = 64
) (
    input  logic         CLK,
    input  logic         RST,
    creg_arbiter_if.slave bus
);

    localparam int PTR_W  = idx_w(NREQ);
    localparam int HOLD_W = $clog2(LOCK_MAX + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LOCK_MAX);

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [15:0]         conflict_cnt_q, conflict_cnt_d;
    logic                lock_err_q, lock_err_d;

    logic [NREQ-1:0]     rr_grant;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     stall;
    logic [PTR_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic [REG_W-1:0]    rf_dst;
    logic [DATA_W-1:0]   rf_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NREQ - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.wr_req),
        .ptr   (rr_ptr_q),
        .grant (rr_grant)
    );

    // While locked only the owner may write; reset forces every grant low.
    always_comb begin
        grant = '0;
        if (!RST) begin
            if (state_q == LOCKED) begin
                grant[owner_q] = bus.wr_req[owner_q];
            end else begin
                grant = rr_grant;
            end
        end
    end

    // Grant is one-hot, so the last match is the only match.
    always_comb begin
        gnt_idx = '0;
        rf_dst  = '0;
        rf_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_idx = PTR_W'(i);
                rf_dst  = bus.wr_dst[REG_W*i +: REG_W];
                rf_data = bus.wr_data[DATA_W*i +: DATA_W];
            end
        end
    end

    assign gnt_any = |grant;

    // Non-owners are also frozen on reads while locked so they cannot observe
    // shared state halfway through the owner's read-modify-write.
    always_comb begin
        stall = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!RST) begin
                stall[i] = (bus.wr_req[i] & ~grant[i]) |
                           ((state_q == LOCKED) && (owner_q != PTR_W'(i)) && bus.rd_req[i]);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        hold_cnt_d     = hold_cnt_q;
        lock_err_d     = 1'b0;
        conflict_cnt_d = conflict_cnt_q;

        if ((|(bus.wr_req & ~grant)) && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end

        case (state_q)
            UNLOCKED: begin
                if (gnt_any) begin
                    rr_ptr_d = ptr_inc(gnt_idx);
                    // Only the granted requester can acquire, which settles simultaneous lock requests.
                    if (bus.lock[gnt_idx]) begin
                        state_d    = LOCKED;
                        owner_d    = gnt_idx;
                        hold_cnt_d = HOLD_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (!bus.lock[owner_q]) begin
                    state_d    = UNLOCKED;
                    owner_d    = '0;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    // Forced release: hand priority to the next requester so the
                    // former owner cannot immediately re-acquire over a waiter.
                    state_d    = UNLOCKED;
                    owner_d    = '0;
                    hold_cnt_d = '0;
                    lock_err_d = 1'b1;
                    rr_ptr_d   = ptr_inc(owner_q);
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= UNLOCKED;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            hold_cnt_q     <= '0;
            conflict_cnt_q <= '0;
            lock_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            hold_cnt_q     <= hold_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
            lock_err_q     <= lock_err_d;
        end
    end

    assign bus.grant        = grant;
    assign bus.stall        = stall;
    assign bus.rf_we        = gnt_any;
    assign bus.rf_dst       = rf_dst;
    assign bus.rf_data      = rf_data;
    assign bus.locked       = (state_q == LOCKED);
    assign bus.owner        = owner_q;
    assign bus.lock_err     = lock_err_q;
    assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_creg_arbiter.sv
// Self-checking bench for creg_arbiter: vector table, lock corner cases, random traffic vs. a reference model.
// Latency: inputs applied 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: stalled requesters keep their requests asserted, as a processor pipeline would.
module tb_creg_arbiter;
    import creg_pkg::*;

    localparam int N  = 2;
    localparam int LM = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    creg_arbiter_if #(.NREQ(N)) bus();

    creg_arbiter #(.NREQ(N), .LOCK_MAX(LM)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state, kept in plain integers.
    bit m_locked;
    int m_owner;
    int m_rr;
    int m_hold;
    int m_cnt;
    bit m_err;

    typedef struct {
        logic [1:0]  wr;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  eg;
        logic [1:0]  es;
        logic [31:0] ed;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [N-1:0] wr, input logic [N-1:0] rd, input logic [N-1:0] lk,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [4:0] t0, input logic [4:0] t1);
        bus.wr_req  = wr;
        bus.rd_req  = rd;
        bus.lock    = lk;
        bus.wr_data = {d1, d0};
        bus.wr_dst  = {t1, t0};
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_owner  = 0;
        m_rr     = 0;
        m_hold   = 0;
        m_cnt    = 0;
        m_err    = 0;
    endtask

    // Index of the requester that should win this cycle, -1 for none.
    function automatic int exp_gidx();
        if (RST) return -1;
        if (m_locked) return bus.wr_req[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (bus.wr_req[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int  g;
        bit  err;
        bit  lost;
        if (RST) begin
            model_reset();
            return;
        end
        g    = exp_gidx();
        err  = 0;
        lost = 0;
        for (int i = 0; i < N; i++) if (bus.wr_req[i] && i != g) lost = 1;
        if (lost && m_cnt < 65535) m_cnt++;
        if (!m_locked) begin
            if (g >= 0) begin
                m_rr = (g + 1) % N;
                if (bus.lock[g]) begin
                    m_locked = 1;
                    m_owner  = g;
                    m_hold   = 1;
                end
            end
        end else if (!bus.lock[m_owner]) begin
            m_locked = 0;
            m_owner  = 0;
            m_hold   = 0;
        end else if (m_hold == LM) begin
            err      = 1;
            m_rr     = (m_owner + 1) % N;
            m_locked = 0;
            m_owner  = 0;
            m_hold   = 0;
        end else begin
            m_hold++;
        end
        m_err = err;
    endtask

    task automatic check_all(input string tag);
        int          g;
        logic [N-1:0] eg;
        logic [N-1:0] es;
        logic [31:0]  ed;
        logic [4:0]   et;
        g  = exp_gidx();
        eg = '0;
        es = '0;
        ed = '0;
        et = '0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            ed    = bus.wr_data[32*g +: 32];
            et    = bus.wr_dst[5*g +: 5];
        end
        for (int i = 0; i < N; i++)
            es[i] = !RST && ((bus.wr_req[i] && !eg[i]) || (m_locked && m_owner != i && bus.rd_req[i]));
        chk({tag, ".grant"},    bus.grant,        eg);
        chk({tag, ".stall"},    bus.stall,        es);
        chk({tag, ".rf_we"},    bus.rf_we,        (g >= 0));
        chk({tag, ".rf_dst"},   bus.rf_dst,       et);
        chk({tag, ".rf_data"},  bus.rf_data,      ed);
        chk({tag, ".locked"},   bus.locked,       m_locked);
        chk({tag, ".owner"},    bus.owner,        m_owner);
        chk({tag, ".lock_err"}, bus.lock_err,     m_err);
        chk({tag, ".cnt"},      bus.conflict_cnt, m_cnt);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive('0, '0, '0, 0, 0, 0, 0);
        model_reset();
        #1;
        check_all("reset");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        int locked_cyc;

        drive('0, '0, '0, 0, 0, 0, 0);
        model_reset();

        // Contention, lone requester 1, idle, lone requester 0.
        tbl[0] = '{2'b11, 32'd5, 32'd9, 2'b01, 2'b10, 32'd5, 16'd0};
        tbl[1] = '{2'b11, 32'd5, 32'd9, 2'b10, 2'b01, 32'd9, 16'd1};
        tbl[2] = '{2'b11, 32'd5, 32'd9, 2'b01, 2'b10, 32'd5, 16'd2};
        tbl[3] = '{2'b11, 32'd5, 32'd9, 2'b10, 2'b01, 32'd9, 16'd3};
        tbl[4] = '{2'b10, 32'd5, 32'd7, 2'b10, 2'b00, 32'd7, 16'd4};
        tbl[5] = '{2'b11, 32'd5, 32'd9, 2'b01, 2'b10, 32'd5, 16'd4};
        tbl[6] = '{2'b00, 32'd5, 32'd9, 2'b00, 2'b00, 32'd0, 16'd5};
        tbl[7] = '{2'b01, 32'd5, 32'd9, 2'b01, 2'b00, 32'd5, 16'd5};

        do_reset();
        for (int v = 0; v < 8; v++) begin
            drive(tbl[v].wr, 2'b00, 2'b00, tbl[v].d0, tbl[v].d1, CREG_IDX, CREG_IDX);
            #4;
            chk($sformatf("tbl%0d.grant", v),   bus.grant,        tbl[v].eg);
            chk($sformatf("tbl%0d.stall", v),   bus.stall,        tbl[v].es);
            chk($sformatf("tbl%0d.rf_we", v),   bus.rf_we,        (tbl[v].eg != 2'b00));
            chk($sformatf("tbl%0d.rf_dst", v),  bus.rf_dst,       (tbl[v].eg != 2'b00) ? CREG_IDX : 5'd0);
            chk($sformatf("tbl%0d.rf_data", v), bus.rf_data,      tbl[v].ed);
            chk($sformatf("tbl%0d.cnt", v),     bus.conflict_cnt, tbl[v].ec);
            tick();
        end

        // Lock held 4 cycles by requester 0 while requester 1 reads and writes.
        do_reset();
        drive(2'b11, 2'b10, 2'b01, 32'h11, 32'h22, CREG_IDX, CREG_IDX);
        #4;
        chk("acq.grant", bus.grant, 2'b01);
        check_all("acq");
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(2'b10, 2'b10, 2'b01, 32'h11, 32'h22, CREG_IDX, CREG_IDX);
            #4;
            chk("hold.locked", bus.locked, 1'b1);
            chk("hold.owner", bus.owner, 1'b0);
            chk("hold.stall1", bus.stall[1], 1'b1);
            check_all("hold");
            tick();
        end
        drive(2'b10, 2'b10, 2'b00, 32'h11, 32'h22, CREG_IDX, CREG_IDX);
        #4;
        chk("rel.stall1", bus.stall[1], 1'b1);
        check_all("rel");
        tick();
        #4;
        chk("after_rel.grant", bus.grant, 2'b10);
        chk("after_rel.locked", bus.locked, 1'b0);
        check_all("after_rel");
        tick();

        // Forced release after LM locked cycles.
        do_reset();
        drive(2'b01, 2'b00, 2'b01, 32'h33, 32'h44, CREG_IDX, CREG_IDX);
        #4;
        check_all("facq");
        tick();
        locked_cyc = 0;
        for (int c = 0; c < LM; c++) begin
            drive(2'b10, 2'b00, 2'b01, 32'h33, 32'h44, CREG_IDX, CREG_IDX);
            #4;
            if (bus.locked) locked_cyc++;
            chk("forced.err_low", bus.lock_err, 1'b0);
            check_all("forced");
            tick();
        end
        #4;
        chk("forced.locked_cycles", locked_cyc, LM);
        chk("forced.locked", bus.locked, 1'b0);
        chk("forced.err", bus.lock_err, 1'b1);
        chk("forced.grant1", bus.grant, 2'b10);
        check_all("forced_rel");
        tick();
        drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
        #4;
        chk("forced.err_once", bus.lock_err, 1'b0);
        tick();

        // Asynchronous reset in the middle of a lock.
        do_reset();
        drive(2'b01, 2'b00, 2'b01, 32'h55, 32'h66, CREG_IDX, CREG_IDX);
        #4;
        tick();
        drive(2'b11, 2'b10, 2'b01, 32'h55, 32'h66, CREG_IDX, CREG_IDX);
        #4;
        chk("pre_rst.stall", bus.stall, 2'b10);
        chk("pre_rst.locked", bus.locked, 1'b1);
        #1;
        RST = 1'b1;
        #1;
        chk("mid_rst.locked", bus.locked, 1'b0);
        chk("mid_rst.stall", bus.stall, 2'b00);
        chk("mid_rst.grant", bus.grant, 2'b00);
        chk("mid_rst.rf_we", bus.rf_we, 1'b0);
        chk("mid_rst.rf_data", bus.rf_data, 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        drive(2'b11, 2'b00, 2'b00, 32'h55, 32'h66, CREG_IDX, CREG_IDX);
        #4;
        chk("post_rst.grant", bus.grant, 2'b01);
        check_all("post_rst");
        tick();

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] lk;
            for (int i = 0; i < N; i++) lk[i] = ($urandom_range(0, 3) != 0);
            drive(N'($urandom), N'($urandom), lk, $urandom, $urandom,
                  5'($urandom), 5'($urandom));
            #4;
            check_all("rnd");
            tick();
        end

        // Saturation of the conflict counter.
        do_reset();
        drive(2'b11, 2'b00, 2'b00, 32'd5, 32'd9, CREG_IDX, CREG_IDX);
        repeat (70000) tick();
        #4;
        chk("sat.cnt", bus.conflict_cnt, 16'hFFFF);
        check_all("sat");
        tick();
        tick();
        #4;
        chk("sat.hold", bus.conflict_cnt, 16'hFFFF);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/creg_arbiter.md
# creg_arbiter

Arbiter and lock controller for the shared common register file (CREG write port) between NREQ pipelined processors. Each cycle it selects at most one write among the requesting processors by round-robin and drives the single shared write port. It stalls the losers, and supports an exclusive lock so one processor can do an atomic read-modify-write of shared state. It replaces the fixed "processor 1 always wins" stall logic in front of the shared register file.

## Interface
- NREQ, 2: number of processor requesters (2..8)
- LOCK_MAX, 64: maximum consecutive cycles a lock may be held before forced release
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- wr_req  in  NREQ  requester i wants to write the shared register file this cycle (its EX stage)
- rd_req  in  NREQ  requester i reads a shared register this cycle (its ID stage)
- lock  in  NREQ  requester i asks for, or keeps, exclusive ownership
- wr_dst  in  NREQ*5  packed destination register numbers; slice i = [5*i+4:5*i]
- wr_data  in  NREQ*32  packed write data; slice i = [32*i+31:32*i]
- grant  out  NREQ  one-hot (or zero) write grant, combinational
- stall  out  NREQ  freeze requester i's pipeline this cycle, combinational
- rf_we  out  1  shared register file write enable
- rf_dst  out  5  shared write destination
- rf_data  out  32  shared write data
- locked  out  1  a lock is currently held (registered)
- owner  out  $clog2(NREQ)  current lock owner (registered; 0 when unlocked)
- lock_err  out  1  one-cycle pulse on forced lock release
- conflict_cnt  out  16  saturating count of cycles in which at least one wr_req was stalled

## Operation
- State: UNLOCKED or LOCKED. Registers: rr_ptr, owner, hold_cnt, conflict_cnt, lock_err.
- UNLOCKED grant: the first asserted wr_req at or after rr_ptr, searching upward modulo NREQ.
- LOCKED grant: grant[owner] = wr_req[owner]. All other grants are 0.
- rf_we = |grant. rf_dst and rf_data are muxed from the granted slice. With no grant, rf_dst and rf_data are 0.
- stall[i] = (wr_req[i] & ~grant[i]) | (LOCKED & owner != i & rd_req[i]).
- rr_ptr update: on any grant to i while UNLOCKED, rr_ptr <= (i+1) mod NREQ. rr_ptr is unchanged while LOCKED.
- UNLOCKED -> LOCKED: requester i is granted a write while lock[i]=1. Then owner <= i and hold_cnt <= 1.
- LOCKED -> UNLOCKED in either of two cases:
  - lock[owner]=0 at a clock edge (normal release). No pulse.
  - hold_cnt == LOCK_MAX with lock[owner] still 1 (forced release). lock_err pulses for 1 cycle and rr_ptr <= owner+1.
- In both cases owner <= 0 and hold_cnt <= 0.
- hold_cnt increments every LOCKED cycle. It saturates at LOCK_MAX.
- conflict_cnt increments when any (wr_req & ~grant) bit is set. It holds at 16'hFFFF.
- Simultaneous lock requests are resolved by the write grant itself: only the granted requester can acquire. The others stall and retry.

## Timing
- Grant, stall, rf_we, rf_dst and rf_data are all combinational from the inputs and the registered state in the same cycle, so there are zero cycles of latency to the register file write.
- The registered state changes on the rising edge after the deciding cycle. locked is visible one cycle after the acquiring write.
- A stalled requester holds wr_req, wr_dst and wr_data stable. Its grant arrives in a later cycle with no further handshake.
- Fairness bound: a persistent UNLOCKED requester is granted within NREQ cycles.
- Lock starvation bound: a locked-out requester waits at most LOCK_MAX+NREQ cycles.
- Reset (asynchronous, any time, including mid-lock): state UNLOCKED, rr_ptr=0, owner=0, hold_cnt=0, conflict_cnt=0, lock_err=0, locked=0.
- While RST=1, grant, stall and rf_we are forced to 0, and rf_dst and rf_data are 0.

## Structure
- Shared package creg_pkg:
  - CREG_IDX = 5'd26
  - REG_W = 5 and DATA_W = 32
  - state enum {UNLOCKED, LOCKED}
- Sub-module rr_pick (NREQ): inputs req vector and ptr; output one-hot grant. It is purely combinational and is reused for any future shared-port arbitration.

## Test plan
- NREQ=2, reset, then wr_req=2'b11 every cycle with dst=26 and data 5 (requester 0) and 9 (requester 1):
  - Grants alternate 01, 10, 01, ...
  - rf_data alternates 5, 9.
  - The loser is stalled each cycle.
  - conflict_cnt increments by 1 per cycle.
- Requester 1 alone, wr_req=2'b10, data=7: grant=10, stall=00, rf_we=1, rf_data=7 in the same cycle. After the edge, rr_ptr=0.
- Requester 0 writes with lock[0]=1 and holds lock 4 cycles while requester 1 asserts rd_req and wr_req:
  - locked=1 and owner=0 from the next cycle.
  - stall[1]=1 throughout.
  - When lock[0] drops, requester 1 is granted the cycle after release.
- LOCK_MAX=8, requester 0 holds lock indefinitely:
  - Forced release after 8 LOCKED cycles.
  - lock_err=1 for exactly one cycle.
  - Requester 1 is granted next.
- Assert RST mid-lock with requester 1 stalled:
  - locked, stall, grant and rf_we drop to 0 immediately, without waiting for CLK.
  - After RST deasserts, the first contended grant goes to requester 0.
- Drive 70000 contended cycles: conflict_cnt saturates at 16'hFFFF and does not wrap.
